// File: rtl/floating_point_delay_line_if.sv
// ----------------------------------------------------------------------------
// floating_point_delay_line_if
//   Bundles the stream and control signals of floating_point_delay_line.
//   master : producer/consumer side (drives fp_i/valid_i/stall_i/flush_i)
//   slave  : the delay line itself (drives fp_o/valid_o/count_o)
// Parameters
//   DATA_WIDTH : NUM_CHANNELS * (1 + EXP_WIDTH + FRAC_WIDTH)
//   CNT_WIDTH  : occupancy counter width, $clog2(LATENCY+1) with a minimum of 1
// Signals
//   fp_i / fp_o       packed FP words, channel k at [k*W +: W]
//   valid_i / valid_o beat valid in / delayed valid out
//   stall_i           hold the whole pipeline
//   flush_i           invalidate all in-flight beats
//   count_o           number of valid beats held in the stages
// ----------------------------------------------------------------------------
interface floating_point_delay_line_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 3
);
  logic [DATA_WIDTH-1:0] fp_i;
  logic                  valid_i;
  logic                  stall_i;
  logic                  flush_i;
  logic [DATA_WIDTH-1:0] fp_o;
  logic                  valid_o;
  logic [CNT_WIDTH-1:0]  count_o;

  modport master (
    output fp_i, valid_i, stall_i, flush_i,
    input  fp_o, valid_o, count_o
  );

  modport slave (
    input  fp_i, valid_i, stall_i, flush_i,
    output fp_o, valid_o, count_o
  );
endinterface

// File: rtl/floating_point_delay_line.sv
// ----------------------------------------------------------------------------
// floating_point_delay_line
//   Multi-channel latency-matching pipeline for FP streams. Delays the packed
//   word bundle plus a shared valid by exactly LATENCY enabled cycles, with a
//   global stall, a synchronous flush and an up/down occupancy counter.
//   FP contents are never interpreted; channels are plain bit-slices.
// Ports
//   clk_i   : clock, all state on the rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : floating_point_delay_line_if.slave (fp/valid/stall/flush in,
//             fp/valid/count out)
// Parameters
//   EXP_WIDTH, FRAC_WIDTH : FP word layout
//   NUM_CHANNELS          : words per beat (1..16)
//   LATENCY               : register stages (0..64), 0 = combinational
//   DATA_RESET            : 1 also clears the data stages on reset
// The interface must be built with DATA_WIDTH = NUM_CHANNELS*FP_WIDTH_REG and
// CNT_WIDTH equal to the local CNT_WIDTH below.
// ----------------------------------------------------------------------------
module floating_point_delay_line #(
  parameter int EXP_WIDTH    = 8,
  parameter int FRAC_WIDTH   = 23,
  parameter int NUM_CHANNELS = 1,
  parameter int LATENCY      = 7,
  parameter bit DATA_RESET   = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  floating_point_delay_line_if.slave    bus
);

  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int DATA_WIDTH   = NUM_CHANNELS * FP_WIDTH_REG;
  localparam int CNT_WIDTH    = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  if (LATENCY == 0) begin : g_bypass
    // Pure wires: stall has nothing to hold, flush only masks the valid.
    assign bus.fp_o    = bus.fp_i;
    assign bus.valid_o = bus.valid_i & ~bus.flush_i;
    assign bus.count_o = '0;
  end else begin : g_pipe
    logic [DATA_WIDTH-1:0] data_q [LATENCY];
    logic [LATENCY-1:0]    vld_q, vld_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  adv;

    // Valid and data share this enable so they can never skew.
    assign adv = ~bus.stall_i;

    always_comb begin
      // NOTE: defaults first so every path assigns every output; otherwise a
      // latch is inferred for the hold case.
      vld_d = vld_q;
      cnt_d = cnt_q;
      if (bus.flush_i) begin
        vld_d = '0;
        cnt_d = '0;
      end else if (adv) begin
        vld_d[0] = bus.valid_i;
        for (int i = 1; i < LATENCY; i++) begin
          vld_d[i] = vld_q[i-1];
        end
        // Entering and leaving beats cancel; the counter is never recomputed.
        cnt_d = cnt_q + CNT_WIDTH'(bus.valid_i) - CNT_WIDTH'(vld_q[LATENCY-1]);
      end
    end

    // NOTE: state is updated with non-blocking assignments so every stage
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        cnt_q <= '0;
      end else begin
        vld_q <= vld_d;
        cnt_q <= cnt_d;
      end
    end

    // Data stages ignore flush: their contents are don't-care once the
    // matching valid bits are cleared.
    if (DATA_RESET) begin : g_data_rst
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < LATENCY; i++) begin
            data_q[i] <= '0;
          end
        end else if (adv) begin
          data_q[0] <= bus.fp_i;
          for (int i = 1; i < LATENCY; i++) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end else begin : g_data_norst
      // NOTE: the wide data array carries no reset; valid qualifies it, and
      // leaving it out lets it map to reset-less flops or shift RAM.
      always_ff @(posedge clk_i) begin
        if (adv) begin
          data_q[0] <= bus.fp_i;
          for (int i = 1; i < LATENCY; i++) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end

    assign bus.fp_o    = data_q[LATENCY-1];
    assign bus.valid_o = vld_q[LATENCY-1];
    assign bus.count_o = cnt_q;
  end

endmodule

// File: tb/tb_floating_point_delay_line.sv
// ----------------------------------------------------------------------------
// tb_floating_point_delay_line
//   Three instances: LATENCY=7 / 2 channels / DATA_RESET=1 (scoreboarded plus
//   directed sequences), LATENCY=0 and LATENCY=1 (table-driven vectors).
//   Inputs change on the falling edge, outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_floating_point_delay_line;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  floating_point_delay_line_if #(.DATA_WIDTH(64), .CNT_WIDTH(3)) if7 ();
  floating_point_delay_line_if #(.DATA_WIDTH(32), .CNT_WIDTH(1)) if0 ();
  floating_point_delay_line_if #(.DATA_WIDTH(32), .CNT_WIDTH(1)) if1 ();

  floating_point_delay_line #(
    .EXP_WIDTH(8), .FRAC_WIDTH(23), .NUM_CHANNELS(2), .LATENCY(7), .DATA_RESET(1'b1)
  ) u_dut7 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if7.slave)
  );

  floating_point_delay_line #(
    .EXP_WIDTH(8), .FRAC_WIDTH(23), .NUM_CHANNELS(1), .LATENCY(0), .DATA_RESET(1'b0)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if0.slave)
  );

  floating_point_delay_line #(
    .EXP_WIDTH(8), .FRAC_WIDTH(23), .NUM_CHANNELS(1), .LATENCY(1), .DATA_RESET(1'b0)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if1.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard for the LATENCY=7 instance ----------------
  logic [63:0] q7[$];
  logic        last_adv;

  // Beats accepted on an advance edge are expected later, in order.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q7.delete();
      last_adv <= 1'b0;
    end else begin
      if (if7.flush_i) q7.delete();
      else if (!if7.stall_i && if7.valid_i) q7.push_back(if7.fp_i);
      last_adv <= !if7.stall_i && !if7.flush_i;
    end
  end

  // A fresh output beat is one seen after an advance edge (stall holds valid_o).
  always @(negedge clk) begin
    if (rst_n && last_adv && if7.valid_o) begin
      if (q7.size() == 0) check("sb_unexpected_beat", 64'(if7.valid_o), 64'(0));
      else                check("sb_beat_data", if7.fp_o, q7.pop_front());
    end
  end

  // ---------------- vector tables ----------------
  typedef struct {
    logic [31:0] fp;
    logic        valid;
    logic        stall;
    logic        flush;
    logic [31:0] exp_fp;
    logic        exp_valid;
    logic        exp_count;
  } vec_t;

  vec_t t0[5];
  vec_t t1[9];

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] beat;
    int cnt_exp, entered, left;

    // LATENCY=0: combinational, stall ignored, flush masks valid; NaN/inf/denormal untouched.
    t0[0] = '{32'h7FC00000, 1'b1, 1'b0, 1'b0, 32'h7FC00000, 1'b1, 1'b0};
    t0[1] = '{32'h7F800000, 1'b1, 1'b0, 1'b1, 32'h7F800000, 1'b0, 1'b0};
    t0[2] = '{32'h00000001, 1'b0, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
    t0[3] = '{32'h3F800000, 1'b1, 1'b1, 1'b0, 32'h3F800000, 1'b1, 1'b0};
    t0[4] = '{32'hFF800000, 1'b1, 1'b1, 1'b1, 32'hFF800000, 1'b0, 1'b0};
    // LATENCY=1: expected outputs after the edge that captures the row.
    t1[0] = '{32'h00000011, 1'b1, 1'b0, 1'b0, 32'h00000011, 1'b1, 1'b1};
    t1[1] = '{32'h00000022, 1'b1, 1'b0, 1'b0, 32'h00000022, 1'b1, 1'b1};
    t1[2] = '{32'h00000033, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    t1[3] = '{32'h00000044, 1'b1, 1'b0, 1'b0, 32'h00000044, 1'b1, 1'b1};
    t1[4] = '{32'h00000055, 1'b1, 1'b1, 1'b0, 32'h00000044, 1'b1, 1'b1};
    t1[5] = '{32'h00000066, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0};
    t1[6] = '{32'h00000077, 1'b1, 1'b0, 1'b0, 32'h00000077, 1'b1, 1'b1};
    t1[7] = '{32'h00000088, 1'b1, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0};
    t1[8] = '{32'h00000099, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};

    if7.fp_i = '0; if7.valid_i = 1'b0; if7.stall_i = 1'b0; if7.flush_i = 1'b0;
    if0.fp_i = '0; if0.valid_i = 1'b0; if0.stall_i = 1'b0; if0.flush_i = 1'b0;
    if1.fp_i = '0; if1.valid_i = 1'b0; if1.stall_i = 1'b0; if1.flush_i = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_valid7", 64'(if7.valid_o), 64'(0));
    check("rst_count7", 64'(if7.count_o), 64'(0));
    check("rst_fp7_data_reset", if7.fp_o, 64'(0));
    rst_n = 1'b1;

    // ---- LATENCY=0 table ----
    for (int i = 0; i < 5; i++) begin
      if0.fp_i = t0[i].fp; if0.valid_i = t0[i].valid;
      if0.stall_i = t0[i].stall; if0.flush_i = t0[i].flush;
      #1;
      check($sformatf("lat0_fp[%0d]", i), 64'(if0.fp_o), 64'(t0[i].exp_fp));
      check($sformatf("lat0_valid[%0d]", i), 64'(if0.valid_o), 64'(t0[i].exp_valid));
      check($sformatf("lat0_count[%0d]", i), 64'(if0.count_o), 64'(t0[i].exp_count));
    end
    if0.valid_i = 1'b0; if0.stall_i = 1'b0; if0.flush_i = 1'b0;

    // ---- LATENCY=1 table ----
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      if1.fp_i = t1[i].fp; if1.valid_i = t1[i].valid;
      if1.stall_i = t1[i].stall; if1.flush_i = t1[i].flush;
      @(negedge clk);
      check($sformatf("lat1_valid[%0d]", i), 64'(if1.valid_o), 64'(t1[i].exp_valid));
      check($sformatf("lat1_count[%0d]", i), 64'(if1.count_o), 64'(t1[i].exp_count));
      if (t1[i].exp_valid) check($sformatf("lat1_fp[%0d]", i), 64'(if1.fp_o), 64'(t1[i].exp_fp));
    end
    if1.valid_i = 1'b0; if1.stall_i = 1'b0; if1.flush_i = 1'b0;

    // ---- LATENCY=7: reset mid-stream, then single-beat latency ----
    for (int i = 0; i < 3; i++) begin
      if7.fp_i = {32'hAAAA0000 + 32'(i), 32'h5555_0000};
      if7.valid_i = 1'b1;
      @(negedge clk);
    end
    if7.valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(if7.valid_o), 64'(0));
    check("midrst_count", 64'(if7.count_o), 64'(0));
    check("midrst_fp", if7.fp_o, 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_count", 64'(if7.count_o), 64'(0));

    beat = {32'h3F800000, 32'h40000000};
    if7.fp_i = beat; if7.valid_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if7.valid_i = 1'b0;
      check($sformatf("lat7_valid[%0d]", k), 64'(if7.valid_o), 64'(k == 7));
      check($sformatf("lat7_count[%0d]", k), 64'(if7.count_o), 64'(k <= 7));
      if (k == 7) check("lat7_fp", if7.fp_o, beat);
    end

    // ---- back-to-back: 20 beats ----
    for (int k = 1; k <= 28; k++) begin
      if7.valid_i = (k <= 20);
      if7.fp_i = {32'(k), 32'(k) + 32'h100};
      @(negedge clk);
      entered = (k < 20) ? k : 20;
      left = (k > 7) ? (((k - 7) < 20) ? (k - 7) : 20) : 0;
      cnt_exp = entered - left;
      check($sformatf("b2b_valid[%0d]", k), 64'(if7.valid_o), 64'(k >= 7 && k <= 26));
      check($sformatf("b2b_count[%0d]", k), 64'(if7.count_o), 64'(cnt_exp));
      if (k >= 7 && k <= 26)
        check($sformatf("b2b_fp[%0d]", k), if7.fp_o, {32'(k - 6), 32'(k - 6) + 32'h100});
    end

    // ---- stall: 3 stalled edges with junk at the input ----
    for (int k = 1; k <= 12; k++) begin
      if7.stall_i = (k >= 4 && k <= 6);
      if7.valid_i = (k == 1) || (k >= 4 && k <= 6);
      if7.fp_i = (k == 1) ? 64'hC0490FDB_7F7FFFFF : 64'hDEADBEEF_DEADBEEF;
      @(negedge clk);
      check($sformatf("stall_count[%0d]", k), 64'(if7.count_o), 64'(k <= 10));
      check($sformatf("stall_valid[%0d]", k), 64'(if7.valid_o), 64'(k == 10));
      if (k == 10) check("stall_fp", if7.fp_o, 64'hC0490FDB_7F7FFFFF);
    end
    if7.stall_i = 1'b0; if7.valid_i = 1'b0;

    // ---- flush together with stall and valid ----
    for (int k = 1; k <= 5; k++) begin
      if7.valid_i = 1'b1;
      if7.fp_i = {32'h1000 + 32'(k), 32'h2000 + 32'(k)};
      @(negedge clk);
    end
    check("flush_pre_count", 64'(if7.count_o), 64'(5));
    if7.flush_i = 1'b1; if7.stall_i = 1'b1; if7.valid_i = 1'b1;
    if7.fp_i = 64'hBAD0BAD0_BAD0BAD0;
    @(negedge clk);
    if7.flush_i = 1'b0; if7.stall_i = 1'b0; if7.valid_i = 1'b0;
    check("flush_count", 64'(if7.count_o), 64'(0));
    check("flush_valid", 64'(if7.valid_o), 64'(0));
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("flush_quiet[%0d]", k), 64'(if7.valid_o), 64'(0));
    end

    // ---- async reset pulse while 4 beats are in flight ----
    for (int k = 1; k <= 4; k++) begin
      if7.valid_i = 1'b1;
      if7.fp_i = {32'h7FC00000, 32'h00000001 + 32'(k)};
      @(negedge clk);
    end
    if7.valid_i = 1'b0;
    check("arst_pre_count", 64'(if7.count_o), 64'(4));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(if7.valid_o), 64'(0));
    check("arst_count", 64'(if7.count_o), 64'(0));
    check("arst_fp", if7.fp_o, 64'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("arst_quiet_valid[%0d]", k), 64'(if7.valid_o), 64'(0));
      check($sformatf("arst_quiet_count[%0d]", k), 64'(if7.count_o), 64'(0));
    end

    check("sb_drained", 64'(q7.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/floating_point_delay_line.md
Name: floating_point_delay_line

Overview:
- Parametrised, multi-channel latency-matching pipeline for floating-point streams.
- Delays a bundle of NUM_CHANNELS FP words plus a shared valid by exactly LATENCY enabled cycles.
- Used to align side streams with arithmetic units of arbitrary depth (adders, multipliers, dividers).
- Adds global stall, synchronous flush and an in-flight occupancy count, none of which a fixed-depth buffer provides.

Parameters:
- EXP_WIDTH, 8, exponent width of each FP word.
- FRAC_WIDTH, 23, fraction width of each FP word.
- NUM_CHANNELS, 1, number of parallel FP words carried per beat (1..16).
- LATENCY, 7, number of register stages (0..64); 0 means combinational pass-through.
- DATA_RESET, 0, when 1 the data registers are also cleared by reset; when 0 only valid/count are reset.
- FP_WIDTH_REG (local), 1+EXP_WIDTH+FRAC_WIDTH, width of one FP word.
- CNT_WIDTH (local), $clog2(LATENCY+1) (min 1), occupancy counter width.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- fp_i  in  NUM_CHANNELS*FP_WIDTH_REG  input words; channel k at bits [k*FP_WIDTH_REG +: FP_WIDTH_REG].
- valid_i  in  1  input beat valid.
- stall_i  in  1  hold the whole pipeline this cycle.
- flush_i  in  1  synchronously invalidate all in-flight beats.
- fp_o  out  NUM_CHANNELS*FP_WIDTH_REG  delayed words, same packing as fp_i.
- valid_o  out  1  delayed valid.
- count_o  out  CNT_WIDTH  number of valid beats currently held in the stages.

Behaviour:
- Reset (rst_ni low, asynchronous): all stage valid bits = 0, valid_o = 0, count_o = 0.
  - DATA_RESET=1: all data stages = 0, so fp_o = 0.
  - DATA_RESET=0: data stages are not reset and fp_o is don't-care until the first valid beat emerges.
- Release from reset: synchronous to clk_i; the first capture occurs on the first rising edge with rst_ni high.
- Advance (stall_i=0, flush_i=0):
  - stage[0] <= {fp_i, valid_i}; stage[i] <= stage[i-1] for i = 1..LATENCY-1.
  - Output = stage[LATENCY-1].
  - A beat presented at edge n appears at the outputs after edge n+LATENCY-1, i.e. LATENCY cycles of latency with no stalls.
- Stall (stall_i=1, flush_i=0):
  - All stages, including valid bits, hold their values.
  - fp_i and valid_i are ignored and the input beat is dropped; upstream must stall in lockstep.
  - valid_o keeps its previous value; consumers qualify it with the same stall.
  - Latency in edges = LATENCY + number of stalled edges in between.
- Flush (flush_i=1): all valid bits are cleared on that edge regardless of stall_i or valid_i.
  - valid_o = 0 and count_o = 0 from the next cycle.
  - Data stages may shift or hold; their values are don't-care.
  - Flush has priority over stall, and the input beat is discarded.
- count_o:
  - Equals the popcount of the stage valid bits; it is maintained as an up/down counter, not recomputed.
  - On an advance edge: +1 if valid_i enters, −1 if stage[LATENCY-1] valid leaves; both or neither gives no change.
  - Never exceeds LATENCY; it holds during stall and is 0 after flush.
- LATENCY=0:
  - fp_o = fp_i, valid_o = valid_i & ~flush_i, count_o = 0.
  - stall_i is ignored and no registers are inferred.
- Channels are independent bit-slices; no arithmetic is performed on FP contents (NaN, inf and denormals pass unchanged).
- Valid and data pipelines share the stall enable, so valid and data never skew.

Test Plan:
- Reset and latency: EXP=8, FRAC=23, LATENCY=7, NUM_CHANNELS=2. Assert rst_ni low mid-stream, then release. Drive one beat fp_i={32'h3F800000,32'h40000000} with valid_i=1.
  -> During reset valid_o=0 and count_o=0. The beat appears exactly 7 cycles after the capture edge with identical contents, and count_o steps 0→1→0.
- Back-to-back: LATENCY=7, drive 20 consecutive beats carrying values 1..20.
  -> The output sequence is 1..20 in order with valid_o continuously high for 20 cycles. count_o reaches 7 and stays there while the pipeline is full.
- Stall: a single beat enters, then stall_i=1 for 3 cycles at stage 3 while valid_i=1 with junk data.
  -> The beat emerges after 10 cycles, no junk beat appears, and count_o stays 1 throughout the stall.
- Flush with simultaneous stall and valid: 5 beats are in flight; assert flush_i=1, stall_i=1 and valid_i=1 in the same cycle.
  -> Next cycle count_o=0, and no valid_o pulse appears for the following 7 cycles.
- LATENCY=0 and LATENCY=1 variants:
  -> For LATENCY=0, fp_o tracks fp_i in the same cycle, and flush_i=1 forces valid_o=0.
  -> For LATENCY=1, there is a one-cycle delay and count_o toggles 0/1 per beat.
- Async reset mid-operation: pulse rst_ni low for half a cycle while 4 beats are in flight.
  -> valid_o and count_o drop to 0 immediately, without waiting for a clock edge, and no stale beat emerges afterwards. With DATA_RESET=1, fp_o reads 0.
